// File: rtl/bw_clk_cclk_en_seq.sv
// Staggered enable sequencer for the cluster-clock inverter branches.
// Branch enables ramp up/down one bit at a time, S=max(stagger,1) cycles apart.
module bw_clk_cclk_en_seq #(
    parameter int NBR   = 8,
    parameter int DLY_W = 4
) (
    input  logic             rclk,
    input  logic             arst_l,
    input  logic             clk_req,
    input  logic [DLY_W-1:0] stagger,
    input  logic             force_on,
    output logic [NBR-1:0]   br_en,
    output logic             clk_ack,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_UP  = 2'd1,
        ST_ON  = 2'd2,
        ST_DN  = 2'd3
    } state_t;

    localparam logic [DLY_W-1:0] CNT_ONE = DLY_W'(1);

    state_t           state_r;
    state_t           state_nx_s;
    logic [NBR-1:0]   therm_r;
    logic [NBR-1:0]   therm_nx_s;
    logic [DLY_W-1:0] cnt_r;
    logic [DLY_W-1:0] cnt_nx_s;
    logic [DLY_W-1:0] reload_s;
    logic             ack_r;
    logic             busy_r;

    // Grow the thermometer by one bit from the bottom.
    function automatic logic [NBR-1:0] therm_up(input logic [NBR-1:0] t);
        return {t[NBR-2:0], 1'b1};
    endfunction

    // Shrink the thermometer by clearing its highest set bit.
    function automatic logic [NBR-1:0] therm_dn(input logic [NBR-1:0] t);
        return {1'b0, t[NBR-1:1]};
    endfunction

    // A stagger of zero behaves as one, so the reload value saturates at zero.
    assign reload_s = (stagger == {DLY_W{1'b0}}) ? {DLY_W{1'b0}} : (stagger - CNT_ONE);

    // Next-state, thermometer and stagger-counter logic.
    always_comb begin
        state_nx_s = state_r;
        therm_nx_s = therm_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_OFF: begin
                if (clk_req) begin
                    therm_nx_s = therm_up(therm_r);
                    cnt_nx_s   = reload_s;
                    state_nx_s = ST_UP;
                end else begin
                    state_nx_s = ST_OFF;
                end
            end
            ST_UP: begin
                if (!clk_req) begin
                    // Reversal: enables hold this edge, first step down is S later.
                    cnt_nx_s   = reload_s;
                    state_nx_s = ST_DN;
                end else if (cnt_r != {DLY_W{1'b0}}) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else begin
                    therm_nx_s = therm_up(therm_r);
                    cnt_nx_s   = reload_s;
                    if (therm_r[NBR-2]) begin
                        state_nx_s = ST_ON;
                    end else begin
                        state_nx_s = ST_UP;
                    end
                end
            end
            ST_ON: begin
                if (!clk_req) begin
                    therm_nx_s = therm_dn(therm_r);
                    cnt_nx_s   = reload_s;
                    state_nx_s = ST_DN;
                end else begin
                    state_nx_s = ST_ON;
                end
            end
            ST_DN: begin
                if (clk_req) begin
                    cnt_nx_s   = reload_s;
                    state_nx_s = ST_UP;
                end else if (cnt_r != {DLY_W{1'b0}}) begin
                    cnt_nx_s = cnt_r - CNT_ONE;
                end else begin
                    therm_nx_s = therm_dn(therm_r);
                    cnt_nx_s   = reload_s;
                    if (!therm_r[1]) begin
                        state_nx_s = ST_OFF;
                    end else begin
                        state_nx_s = ST_DN;
                    end
                end
            end
            default: begin
                state_nx_s = ST_OFF;
                therm_nx_s = {NBR{1'b0}};
                cnt_nx_s   = {DLY_W{1'b0}};
            end
        endcase
    end

    // State, thermometer, counter and status flags, all on rclk.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_r <= ST_OFF;
            therm_r <= {NBR{1'b0}};
            cnt_r   <= {DLY_W{1'b0}};
            ack_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            therm_r <= therm_nx_s;
            cnt_r   <= cnt_nx_s;
            ack_r   <= (state_nx_s == ST_ON);
            busy_r  <= (state_nx_s == ST_UP) || (state_nx_s == ST_DN);
        end
    end

    // Test override bypasses the sequencer without disturbing it.
    assign br_en   = therm_r | {NBR{force_on}};
    assign clk_ack = ack_r;
    assign busy    = busy_r;

endmodule

// File: tb/tb_bw_clk_cclk_en_seq.sv
// Directed self-checking bench for bw_clk_cclk_en_seq (NBR=8, DLY_W=4).
module tb_bw_clk_cclk_en_seq;

    logic       rclk = 1'b0;
    logic       arst_l;
    logic       clk_req;
    logic [3:0] stagger;
    logic       force_on;
    logic [7:0] br_en;
    logic       clk_ack;
    logic       busy;

    int tests  = 0;
    int failed = 0;

    bw_clk_cclk_en_seq #(.NBR(8), .DLY_W(4)) dut (
        .rclk     (rclk),
        .arst_l   (arst_l),
        .clk_req  (clk_req),
        .stagger  (stagger),
        .force_on (force_on),
        .br_en    (br_en),
        .clk_ack  (clk_ack),
        .busy     (busy)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    function automatic logic [7:0] therm_of(input int bits);
        logic [8:0] v;
        v = (9'd1 << bits) - 9'd1;
        return v[7:0];
    endfunction

    function automatic logic is_therm(input logic [7:0] x);
        logic [8:0] v;
        v = {1'b0, x} + 9'd1;
        return ((v & {1'b0, x}) == 9'd0);
    endfunction

    initial begin
        int bits;
        // 1: reset with request asserted, then release with request low
        arst_l = 1'b0; clk_req = 1'b1; force_on = 1'b0; stagger = 4'd2;
        #12;
        check("rst_br_en", {24'd0, br_en}, 32'h00);
        check("rst_ack", {31'd0, clk_ack}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        tick(); tick();
        check("rst_hold_br_en", {24'd0, br_en}, 32'h00);
        clk_req = 1'b0; arst_l = 1'b1;
        tick(); tick(); tick();
        check("idle_br_en", {24'd0, br_en}, 32'h00);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_ack", {31'd0, clk_ack}, 32'd0);

        // 2: ramp up with stagger=2
        stagger = 4'd2; clk_req = 1'b1;
        for (int n = 0; n < 16; n++) begin
            tick();
            bits = (n / 2) + 1;
            if (bits > 8) bits = 8;
            check("up2_br_en", {24'd0, br_en}, {24'd0, therm_of(bits)});
            check("up2_ack", {31'd0, clk_ack}, (n >= 14) ? 32'd1 : 32'd0);
            check("up2_busy", {31'd0, busy}, (n < 14) ? 32'd1 : 32'd0);
        end

        // 5: ramp down from ON with stagger=1
        stagger = 4'd1; clk_req = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            check("dn1_br_en", {24'd0, br_en}, {24'd0, therm_of(7 - n)});
            check("dn1_therm", {31'd0, is_therm(br_en)}, 32'd1);
            check("dn1_ack", {31'd0, clk_ack}, 32'd0);
            check("dn1_busy", {31'd0, busy}, (n < 7) ? 32'd1 : 32'd0);
        end

        // 3: stagger=0 behaves as one cycle per step
        stagger = 4'd0; clk_req = 1'b1;
        for (int n = 0; n < 9; n++) begin
            tick();
            bits = n + 1;
            if (bits > 8) bits = 8;
            check("up0_br_en", {24'd0, br_en}, {24'd0, therm_of(bits)});
            check("up0_ack", {31'd0, clk_ack}, (n >= 7) ? 32'd1 : 32'd0);
        end
        clk_req = 1'b0;
        for (int n = 0; n < 8; n++) tick();
        check("dn0_br_en", {24'd0, br_en}, 32'h00);
        check("dn0_busy", {31'd0, busy}, 32'd0);

        // 4: stagger=3, reverse when three branches are on
        stagger = 4'd3; clk_req = 1'b1;
        for (int n = 0; n < 7; n++) begin
            tick();
            check("up3_br_en", {24'd0, br_en}, {24'd0, therm_of((n / 3) + 1)});
            check("up3_ack", {31'd0, clk_ack}, 32'd0);
        end
        clk_req = 1'b0;
        for (int m = 0; m < 10; m++) begin
            tick();
            check("rev_br_en", {24'd0, br_en}, {24'd0, therm_of(3 - (m / 3))});
            check("rev_ack", {31'd0, clk_ack}, 32'd0);
            check("rev_busy", {31'd0, busy}, (m < 9) ? 32'd1 : 32'd0);
        end

        // 6: force_on in OFF, then asynchronous reset mid-ramp
        force_on = 1'b1;
        tick();
        check("force_br_en", {24'd0, br_en}, 32'hFF);
        check("force_ack", {31'd0, clk_ack}, 32'd0);
        check("force_busy", {31'd0, busy}, 32'd0);
        force_on = 1'b0;
        #1;
        check("unforce_br_en", {24'd0, br_en}, 32'h00);
        stagger = 4'd2; clk_req = 1'b1;
        tick(); tick(); tick();
        check("mid_up_br_en", {24'd0, br_en}, 32'h03);
        #3;
        arst_l = 1'b0;
        #1;
        check("arst_br_en", {24'd0, br_en}, 32'h00);
        check("arst_ack", {31'd0, clk_ack}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        force_on = 1'b1;
        #1;
        check("arst_force_br_en", {24'd0, br_en}, 32'hFF);
        force_on = 1'b0; clk_req = 1'b0;
        #1;
        arst_l = 1'b1;
        tick();
        check("post_arst_br_en", {24'd0, br_en}, 32'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
